lsu_bus_master: RTL and testbench

//  Initiator side of the core's peripheral register bus: converts one core load/store

---
 rtl/lsu_bus_master.sv | 171 +++++++++++++++++
 tb/tb_lsu_bus_master.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_master.sv
// Load/store unit master for the peripheral register bus. Each core request becomes one
// read or write bus cycle and one response pulse. Optional read timeout: LSU_TIMEOUT_EN.
module lsu_bus_master #(
    parameter logic [15:0] ADDR_HI        = 16'h0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        wr_en,
    output logic [3:0]  be,
    output logic [15:0] wr_addr,
    output logic [31:0] wdata,
    output logic        rd_en,
    output logic [15:0] rd_addr,
    input  logic [31:0] rdata,
    input  logic        rd_rdy
);

    typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, RESP} state_t;

    state_t      state, next_state;
    logic        accept, req_bad, rd_done, rd_timeout;
    logic [1:0]  lat_size, lat_off;
    logic        lat_uns;
    logic [15:0] bus_addr;

    logic        wr_en_d, rd_en_d, resp_valid_d, resp_err_d;
    logic [3:0]  be_d;
    logic [15:0] wr_addr_d, rd_addr_d;
    logic [31:0] wdata_d, resp_rdata_d;

    // Extract the addressed lane from the bus word and widen it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = d[{off, 3'b000} +: 8];
        h = d[{off[1], 4'b0000} +: 16];
        case (size)
            2'd0:    return uns ? {24'd0, b} : 32'(b);
            2'd1:    return uns ? {16'd0, h} : 32'(h);
            default: return d;
        endcase
    endfunction

    assign req_ready = (state == IDLE) & ~rst;
    assign accept    = req_valid & req_ready;
    assign rd_done   = (state == RD_WAIT) & rd_rdy;
    assign bus_addr  = {req_addr[15:2], 2'b00};

    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            2'd1:    req_bad = req_addr[0];
            2'd2:    req_bad = |req_addr[1:0];
            2'd3:    req_bad = 1'b1;
            default: req_bad = 1'b0;
        endcase
        if (req_addr[31:16] != ADDR_HI)
            req_bad = 1'b1;
    end

`ifdef LSU_TIMEOUT_EN
    logic [15:0] to_cnt;

    // Held at zero outside RD_WAIT, so it starts from zero on every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            to_cnt <= '0;
        else if (state != RD_WAIT)
            to_cnt <= '0;
        else if (!rd_rdy)
            to_cnt <= to_cnt + 16'd1;
    end

    assign rd_timeout = (state == RD_WAIT) & ~rd_rdy & (to_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign rd_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = req_bad ? RESP : (req_we ? WR : RD);
            WR:      next_state = RESP;
            RD:      next_state = RD_WAIT;
            RD_WAIT: if (rd_done || rd_timeout) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs; bus fields are zero whenever no strobe is issued.
    always_comb begin
        wr_en_d      = (state == IDLE) && (next_state == WR);
        rd_en_d      = (state == IDLE) && (next_state == RD);
        be_d         = 4'b0000;
        wdata_d      = 32'd0;
        wr_addr_d    = wr_en_d ? bus_addr : 16'd0;
        rd_addr_d    = rd_en_d ? bus_addr : 16'd0;
        resp_valid_d = (next_state == RESP);
        resp_err_d   = ((state == IDLE) && (next_state == RESP)) || rd_timeout;
        resp_rdata_d = rd_done ? load_extend(rdata, lat_size, lat_off, lat_uns) : 32'd0;
        if (wr_en_d) begin
            case (req_size)
                2'd0: begin
                    be_d    = 4'b0001 << req_addr[1:0];
                    wdata_d = {4{req_wdata[7:0]}};
                end
                2'd1: begin
                    be_d    = 4'b0011 << {req_addr[1], 1'b0};
                    wdata_d = {2{req_wdata[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = req_wdata;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_size <= req_size;
            lat_off  <= req_addr[1:0];
            lat_uns  <= req_unsigned;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            be         <= 4'b0000;
            wr_addr    <= 16'd0;
            rd_addr    <= 16'd0;
            wdata      <= 32'd0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            wr_en      <= wr_en_d;
            rd_en      <= rd_en_d;
            be         <= be_d;
            wr_addr    <= wr_addr_d;
            rd_addr    <= rd_addr_d;
            wdata      <= wdata_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= resp_rdata_d;
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: loads, stores, error responses, back-to-back
// requests, read wait/timeout and asynchronous reset during a read.
module tb_lsu_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        wr_en;
    logic [3:0]  be;
    logic [15:0] wr_addr;
    logic [31:0] wdata;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [31:0] rdata = 32'd0;
    logic        rd_rdy = 1'b0;

    int checks = 0;
    int errors = 0;

    lsu_bus_master #(.ADDR_HI(16'h0000), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .wr_en(wr_en), .be(be), .wr_addr(wr_addr), .wdata(wdata),
        .rd_en(rd_en), .rd_addr(rd_addr), .rdata(rdata), .rd_rdy(rd_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, {27'd0, resp_valid, resp_err, wr_en, rd_en, req_ready}, 32'd0);
        chk({tag, "_be"}, {28'd0, be}, 32'd0);
        chk({tag, "_addr"}, {wr_addr, rd_addr}, 32'd0);
        chk({tag, "_wdata"}, wdata, 32'd0);
        chk({tag, "_rdata"}, resp_rdata, 32'd0);
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] d);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = d;
    endtask

    task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] bus_d,
                           input logic [31:0] exp_rdata);
        drive_req(1'b0, size, uns, addr, 32'd0);
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        chk({tag, "_rd_en"}, {30'd0, wr_en, rd_en}, 32'd1);
        chk({tag, "_rd_addr"}, {16'd0, rd_addr}, {16'd0, addr[15:2], 2'b00});
        rd_rdy = 1'b1; rdata = 32'hDEAD_BEEF;
        step();
        chk({tag, "_wait"}, {30'd0, rd_en, resp_valid}, 32'd0);
        rdata = bus_d;
        step();
        rd_rdy = 1'b0; rdata = 32'd0;
        chk({tag, "_resp"}, {30'd0, resp_valid, resp_err}, 32'd2);
        chk({tag, "_data"}, resp_rdata, exp_rdata);
        step();
        chk({tag, "_done"}, {30'd0, resp_valid, req_ready}, 32'd1);
    endtask

    task automatic do_store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] d, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
        drive_req(1'b1, size, 1'b0, addr, d);
        step();
        req_valid = 1'b0;
        chk({tag, "_strobe"}, {29'd0, wr_en, rd_en, resp_valid}, 32'd4);
        chk({tag, "_be"}, {28'd0, be}, {28'd0, exp_be});
        chk({tag, "_wdata"}, wdata, exp_wdata);
        chk({tag, "_wr_addr"}, {16'd0, wr_addr}, {16'd0, addr[15:2], 2'b00});
        step();
        chk({tag, "_resp"}, {29'd0, wr_en, resp_valid, resp_err}, 32'd2);
        chk({tag, "_rdata"}, resp_rdata, 32'd0);
        step();
    endtask

    task automatic do_err(input string tag, input logic we, input logic [1:0] size,
                          input logic [31:0] addr);
        drive_req(we, size, 1'b0, addr, 32'hFFFF_FFFF);
        step();
        req_valid = 1'b0;
        chk({tag, "_resp"}, {28'd0, wr_en, rd_en, resp_valid, resp_err}, 32'd3);
        chk({tag, "_rdata"}, resp_rdata, 32'd0);
        step();
        chk({tag, "_after"}, {30'd0, resp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();
        chk("post_reset_ready", {31'd0, req_ready}, 32'd1);

        do_load("lw0", 2'd2, 1'b0, 32'h0000_0000, 32'h11A5_0005, 32'h11A5_0005);
        do_load("lb2", 2'd0, 1'b0, 32'h0000_0002, 32'h11A5_0005, 32'hFFFF_FFA5);
        do_load("lbu2", 2'd0, 1'b1, 32'h0000_0002, 32'h11A5_0005, 32'h0000_00A5);
        do_load("lb0", 2'd0, 1'b0, 32'h0000_0000, 32'h11A5_0005, 32'h0000_0005);
        do_load("lh2", 2'd1, 1'b0, 32'h0000_0002, 32'h11A5_0005, 32'h0000_11A5);
        do_load("lh0", 2'd1, 1'b0, 32'h0000_0008, 32'h0000_8001, 32'hFFFF_8001);
        do_load("lhu0", 2'd1, 1'b1, 32'h0000_0008, 32'h0000_8001, 32'h0000_8001);
        do_load("lb3", 2'd0, 1'b0, 32'h0000_0ABF, 32'h7F00_0000, 32'h0000_007F);

        do_store("sb1", 2'd0, 32'h0000_0001, 32'h0000_005A, 4'b0010, 32'h5A5A_5A5A);
        do_store("sb3", 2'd0, 32'h0000_0103, 32'h0000_0077, 4'b1000, 32'h7777_7777);
        do_store("sh6", 2'd1, 32'h0000_0006, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF);
        do_store("sw10", 2'd2, 32'h0000_0010, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        do_err("sh_misal", 1'b1, 2'd1, 32'h0000_0001);
        do_err("lw_range", 1'b0, 2'd2, 32'h0001_0004);
        do_err("size3", 1'b0, 2'd3, 32'h0000_0000);
        do_err("lw_misal", 1'b0, 2'd2, 32'h0000_0002);

        // Back-to-back stores with req_valid held high.
        drive_req(1'b1, 2'd2, 1'b0, 32'h0000_0020, 32'h0102_0304);
        chk("b2b_ready_n", {31'd0, req_ready}, 32'd1);
        step();
        chk("b2b_ready_n1", {30'd0, req_ready, wr_en}, 32'd1);
        step();
        chk("b2b_ready_resp", {30'd0, req_ready, resp_valid}, 32'd1);
        req_wdata = 32'h0506_0708;
        step();
        chk("b2b_ready_idle", {30'd0, req_ready, wr_en}, 32'd2);
        step();
        req_valid = 1'b0;
        chk("b2b_second_wr", {31'd0, wr_en}, 32'd1);
        chk("b2b_second_wdata", wdata, 32'h0506_0708);
        step();
        chk("b2b_second_resp", {31'd0, resp_valid}, 32'd1);
        step();

        // Read with no rd_rdy from the responder.
        drive_req(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'd0);
        step();
        req_valid = 1'b0;
        step();
`ifdef LSU_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            chk("to_wait", {31'd0, resp_valid}, 32'd0);
            step();
        end
        chk("to_resp", {30'd0, resp_valid, resp_err}, 32'd3);
        chk("to_rdata", resp_rdata, 32'd0);
        step();
        rd_rdy = 1'b1; rdata = 32'h1234_5678;
        step();
        rd_rdy = 1'b0;
        chk("to_late_rdy", {31'd0, resp_valid}, 32'd0);
        step();
`else
        for (int i = 0; i < 20; i++) begin
            chk("wait_no_resp", {31'd0, resp_valid}, 32'd0);
            step();
        end
        rd_rdy = 1'b1; rdata = 32'h1234_5678;
        step();
        rd_rdy = 1'b0;
        chk("wait_resp", {30'd0, resp_valid, resp_err}, 32'd2);
        chk("wait_data", resp_rdata, 32'h1234_5678);
        step();
`endif

        // Reset asserted mid-wait drops the read with no response.
        drive_req(1'b0, 2'd2, 1'b0, 32'h0000_0044, 32'd0);
        step();
        req_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check_all_zero("rst_wait");
        step();
        rst = 1'b0;
        rd_rdy = 1'b1; rdata = 32'hAAAA_AAAA;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_wait_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        rd_rdy = 1'b0;

        // Reset while rd_en is high clears the strobe without waiting for a clock.
        drive_req(1'b0, 2'd2, 1'b0, 32'h0000_0048, 32'd0);
        step();
        req_valid = 1'b0;
        chk("rst_rd_strobe", {31'd0, rd_en}, 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("rst_rd");
        step();
        rst = 1'b0;
        step();
        step();
        chk("rst_rd_no_resp", {31'd0, resp_valid}, 32'd0);

        do_load("lw_after_rst", 2'd2, 1'b0, 32'h0000_004C, 32'h8765_4321, 32'h8765_4321);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
